// File: rtl/collector.sv
// collector: word-to-nibble serializer, MSB nibble first, one nibble per clock.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   data_in    word to serialize, sampled only at the start of each frame
//   data_chunk current nibble (registered)
//   wire1..4   data_chunk[0]..data_chunk[3] as individual lines
module collector #(
    parameter int DATA_WIDTH  = 32,
    parameter int CHUNK_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  data_in,
    output logic                   wire1,
    output logic                   wire2,
    output logic                   wire3,
    output logic                   wire4,
    output logic [CHUNK_WIDTH-1:0] data_chunk
);
    localparam int N  = DATA_WIDTH / CHUNK_WIDTH;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0]          r_idx;
    logic [DATA_WIDTH-1:0]  r_held;
    logic [CHUNK_WIDTH-1:0] r_chunk;
    logic [DATA_WIDTH-1:0]  w_shift;

    // Moving the wanted nibble to the top avoids a variable part-select.
    assign w_shift = r_held << {r_idx, 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_held  <= '0;
            r_chunk <= '0;
        end else begin
            r_idx   <= (r_idx == IW'(N - 1)) ? '0 : r_idx + IW'(1);
            r_held  <= (r_idx == '0) ? data_in : r_held;
            r_chunk <= (r_idx == '0) ? data_in[DATA_WIDTH-1 -: CHUNK_WIDTH]
                                     : w_shift[DATA_WIDTH-1 -: CHUNK_WIDTH];
        end
    end

    assign data_chunk = r_chunk;
    assign {wire4, wire3, wire2, wire1} = r_chunk;
endmodule

// File: tb/tb_collector.sv
// tb_collector: randomized and directed self-checking bench for collector.
module tb_collector;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic        wire1, wire2, wire3, wire4;
    logic [3:0]  data_chunk;

    int checks = 0;
    int errors = 0;

    // Reference model: frame position and the word currently being sent.
    int          m_pos  = 0;
    logic [31:0] m_word = '0;
    logic [3:0]  m_exp  = '0;

    collector dut (
        .clk(clk), .rst(rst), .data_in(data_in),
        .wire1(wire1), .wire2(wire2), .wire3(wire3), .wire4(wire4),
        .data_chunk(data_chunk)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply inputs, clock once, advance the model, then check. e<0 means model only.
    task automatic step(input logic r, input logic [31:0] d, input int e);
        rst     = r;
        data_in = d;
        @(posedge clk);
        if (r) begin
            m_pos  = 0;
            m_word = '0;
            m_exp  = '0;
        end else begin
            if (m_pos == 0) m_word = d;
            m_exp = 4'((m_word >> (28 - 4 * m_pos)) & 32'hF);
            m_pos = (m_pos + 1) % 8;
        end
        #1;
        chk("chunk", 32'(data_chunk), 32'(m_exp));
        chk("wires", 32'({wire4, wire3, wire2, wire1}), 32'(m_exp));
        if (e >= 0) chk("directed", 32'(data_chunk), 32'(e));
    endtask

    initial begin
        int seq1[8] = '{2, 3, 5, 5, 5, 7, 6, 5};
        int seq2[8] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 0, 1};
        rst = 1'b1;
        data_in = '0;
        // Reset holds outputs at zero regardless of data_in.
        for (int i = 0; i < 2; i++) step(1'b1, 32'hFFFFFFFF, 0);
        // Basic frame plus two more back-to-back frames.
        for (int i = 0; i < 24; i++) step(1'b0, 32'h23555765, seq1[i % 8]);
        // Input change mid-frame is ignored until the next frame.
        for (int i = 0; i < 3; i++) step(1'b0, 32'h12345678, i + 1);
        for (int i = 3; i < 8; i++) step(1'b0, 32'hABCDEF01, i + 1);
        for (int i = 0; i < 8; i++) step(1'b0, 32'hABCDEF01, seq2[i]);
        // Reset mid-frame discards the partial word.
        for (int i = 0; i < 5; i++) step(1'b0, 32'h89ABCDEF, 8 + i);
        for (int i = 0; i < 2; i++) step(1'b1, 32'h0F0F0F0F, 0);
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0F0F0F0F, (i % 2 == 1) ? 15 : 0);
        // Random data with data_in changing every cycle and occasional resets.
        for (int i = 0; i < 1000; i++)
            step(($urandom_range(0, 49) == 0), $urandom, -1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
